fft_stream_framer: RTL and testbench

//  Buffers a continuous sample stream from the audio front end and emits Avalon-ST frames
//  of FRAME_LEN samples (valid/sop/eop/data) into the FFT core's sink, honouring backpressure.
//  A frame starts only when FIFO holds a full frame, so valid never drops mid-frame.

---
 rtl/fft_stream_framer.sv | 140 ++++++++++++++
 tb/tb_fft_stream_framer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stream_framer.sv
// Sample FIFO plus Avalon-ST framer: buffers a free-running sample stream and
// emits FRAME_LEN-sample frames (valid/sop/eop) only once a whole frame is buffered.
module fft_stream_framer #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_sample_valid,
  input  logic [DATA_W-1:0]             i_sample,
  input  logic                          i_clear,
  input  logic                          i_sink_ready,
  output logic                          o_valid,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_sop,
  output logic                          o_eop,
  output logic [$clog2(FIFO_DEPTH):0]   o_fill,
  output logic                          o_overflow,
  output logic [15:0]                   o_frame_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(FRAME_LEN);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_fill;
  logic [AW:0]       w_fill_post;
  logic              r_overflow;
  logic              r_clear_pend;
  logic [15:0]       r_frame_cnt;

  logic w_full;
  logic w_pop;
  logic w_last;
  logic w_eop_xfer;
  logic w_do_clear;
  logic w_push;
  logic w_drop;

  // A pending clear is only honoured between frames so a frame is never truncated.
  assign w_full      = (r_fill == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = (r_state == S_STREAM) & i_sink_ready;
  assign w_last      = (r_idx == IW'(FRAME_LEN - 1));
  assign w_eop_xfer  = w_pop & w_last;
  assign w_do_clear  = (i_clear | r_clear_pend) & ((r_state == S_IDLE) | w_eop_xfer);
  assign w_push      = i_sample_valid & (~w_full | w_pop) & ~w_do_clear;
  assign w_drop      = i_sample_valid & w_full & ~w_pop & ~w_do_clear;
  assign w_fill_post = r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);

  assign o_data      = (r_state == S_STREAM) ? r_mem[r_rd_ptr] : '0;
  assign o_fill      = r_fill;
  assign o_overflow  = r_overflow;
  assign o_frame_cnt = r_frame_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    o_valid     = 1'b0;
    o_sop       = 1'b0;
    o_eop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_do_clear && (r_fill >= (AW+1)'(FRAME_LEN))) begin
          w_state_nxt = S_STREAM;
          w_idx_nxt   = '0;
        end
      end
      S_STREAM: begin
        o_valid = 1'b1;
        o_sop   = (r_idx == '0);
        o_eop   = w_last;
        if (w_pop) begin
          if (!w_last) begin
            w_idx_nxt = r_idx + IW'(1);
          end else begin
            // Chain straight into the next frame when one is already buffered.
            w_idx_nxt = '0;
            if (w_do_clear || (w_fill_post < (AW+1)'(FRAME_LEN))) begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_overflow   <= 1'b0;
      r_clear_pend <= 1'b0;
      r_frame_cnt  <= '0;
    end else if (w_do_clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fill       <= '0;
      r_overflow   <= 1'b0;
      r_clear_pend <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_fill <= w_fill_post;
      if (w_drop) r_overflow <= 1'b1;
      if (i_clear) r_clear_pend <= 1'b1;
      if (w_eop_xfer) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Sample storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_sample;
  end

endmodule

// File: tb/tb_fft_stream_framer.sv
// Scoreboard bench for fft_stream_framer: a queue-based frame model predicts every
// transfer and per-cycle status; a separate monitor checks each valid&ready beat.
module tb_fft_stream_framer;

  localparam int DW    = 16;
  localparam int FL    = 8;
  localparam int DEPTH = 16;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_sample_valid;
  logic [DW-1:0] i_sample;
  logic          i_clear;
  logic          i_sink_ready;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic          o_sop;
  logic          o_eop;
  logic [4:0]    o_fill;
  logic          o_overflow;
  logic [15:0]   o_frame_cnt;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } xfer_t;

  xfer_t         expQ[$];
  logic [DW-1:0] mQ[$];
  bit            mStream;
  bit            mOv;
  bit            mPend;
  int            mIdx;
  logic [15:0]   mCnt;

  int vectors     = 0;
  int miscompares = 0;

  fft_stream_framer #(.DATA_W(DW), .FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_sample_valid (i_sample_valid),
    .i_sample       (i_sample),
    .i_clear        (i_clear),
    .i_sink_ready   (i_sink_ready),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_sop          (o_sop),
    .o_eop          (o_eop),
    .o_fill         (o_fill),
    .o_overflow     (o_overflow),
    .o_frame_cnt    (o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mQ.delete();
    expQ.delete();
    mStream = 0;
    mOv     = 0;
    mPend   = 0;
    mIdx    = 0;
    mCnt    = '0;
  endtask

  // Expected status for the current cycle, from the model state before the clock edge.
  task automatic checkOutput();
    check("valid", {31'd0, o_valid}, {31'd0, mStream});
    check("fill", {27'd0, o_fill}, mQ.size());
    check("overflow", {31'd0, o_overflow}, {31'd0, mOv});
    check("frame_cnt", {16'd0, o_frame_cnt}, {16'd0, mCnt});
    if (mStream) begin
      check("head_data", {16'd0, o_data}, {16'd0, mQ[0]});
      check("sop", {31'd0, o_sop}, {31'd0, mIdx == 0});
      check("eop", {31'd0, o_eop}, {31'd0, mIdx == FL - 1});
    end else begin
      check("idle_sop", {31'd0, o_sop}, 32'd0);
      check("idle_eop", {31'd0, o_eop}, 32'd0);
    end
  endtask

  // Frame-level behaviour: buffered samples leave in order, FL per frame.
  task automatic modelStep(input bit sv, input logic [DW-1:0] s, input bit clr, input bit rdy);
    int    sz;
    bit    pop;
    bit    eopX;
    bit    doClr;
    xfer_t e;
    sz    = mQ.size();
    pop   = mStream && rdy;
    eopX  = pop && (mIdx == FL - 1);
    doClr = (clr || mPend) && (!mStream || eopX);
    if (pop) begin
      e.data = mQ[0];
      e.sop  = (mIdx == 0);
      e.eop  = eopX;
      expQ.push_back(e);
    end
    if (doClr) begin
      mQ.delete();
      mOv     = 0;
      mCnt    = '0;
      mPend   = 0;
      mStream = 0;
      mIdx    = 0;
      return;
    end
    if (pop) void'(mQ.pop_front());
    if (sv) begin
      if (sz < DEPTH || pop) mQ.push_back(s);
      else mOv = 1;
    end
    if (eopX) mCnt = mCnt + 16'd1;
    if (clr) mPend = 1;
    if (!mStream) begin
      if (sz >= FL) begin
        mStream = 1;
        mIdx    = 0;
      end
    end else if (pop) begin
      if (mIdx < FL - 1) mIdx++;
      else if (mQ.size() < FL) mStream = 0;
      else mIdx = 0;
    end
  endtask

  task automatic applyStimulus(input bit sv, input logic [DW-1:0] s, input bit clr, input bit rdy);
    @(negedge i_clk);
    i_sample_valid = sv;
    i_sample       = s;
    i_clear        = clr;
    i_sink_ready   = rdy;
    #1;
    checkOutput();
    modelStep(sv, s, clr, rdy);
  endtask

  task automatic drainAndClear();
    for (int k = 0; k < 60 && mStream; k++) applyStimulus(0, '0, 0, 1);
    applyStimulus(0, '0, 1, 1);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_reset_n      = 0;
    i_sample_valid = 0;
    i_clear        = 0;
    #1;
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_sop", {31'd0, o_sop}, 32'd0);
    check("rst_eop", {31'd0, o_eop}, 32'd0);
    check("rst_fill", {27'd0, o_fill}, 32'd0);
    modelReset();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1;
  endtask

  // Monitor: every accepted beat must match the oldest predicted transfer.
  initial begin
    xfer_t e;
    forever begin
      @(negedge i_clk);
      #2;
      if (i_reset_n && o_valid && i_sink_ready) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL xfer_unexpected actual=data %0h required=no transfer at %0t", o_data, $time);
        end else begin
          e = expQ.pop_front();
          check("xfer_data", {16'd0, o_data}, {16'd0, e.data});
          check("xfer_sop", {31'd0, o_sop}, {31'd0, e.sop});
          check("xfer_eop", {31'd0, o_eop}, {31'd0, e.eop});
        end
      end
    end
  end

  initial begin
    int held;
    bit done;
    i_reset_n      = 0;
    i_sample_valid = 0;
    i_sample       = '0;
    i_clear        = 0;
    i_sink_ready   = 0;
    modelReset();
    #12;
    checkOutput();
    @(negedge i_clk);
    i_reset_n = 1;

    $display("[TB] single frame");
    for (int i = 0; i < 8; i++) applyStimulus(1, 16'(i), 0, 1);
    repeat (12) applyStimulus(0, '0, 0, 1);

    $display("[TB] back-to-back frames");
    drainAndClear();
    for (int i = 0; i < 16; i++) applyStimulus(1, 16'(100 + i), 0, 1);
    repeat (20) applyStimulus(0, '0, 0, 1);

    $display("[TB] backpressure hold");
    drainAndClear();
    held = 0;
    for (int i = 0; i < 40; i++) begin
      bit rdy;
      rdy = !(mStream && mIdx == 3 && held < 5);
      if (!rdy) held++;
      applyStimulus(i < 8, 16'(200 + i), 0, rdy);
    end

    $display("[TB] overflow");
    drainAndClear();
    for (int i = 0; i < 17; i++) applyStimulus(1, 16'(300 + i), 0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1, 16'(400 + i), 0, 1);
    repeat (30) applyStimulus(0, '0, 0, 1);

    $display("[TB] clear mid-frame");
    drainAndClear();
    done = 0;
    for (int i = 0; i < 30; i++) begin
      bit clr;
      clr = mStream && mIdx == 4 && !done;
      if (clr) done = 1;
      applyStimulus(1, 16'(500 + i), clr, 1);
    end
    repeat (10) applyStimulus(0, '0, 0, 1);

    $display("[TB] reset mid-frame");
    drainAndClear();
    for (int i = 0; i < 30 && !(mStream && mIdx == 5); i++) applyStimulus(i < 8, 16'(600 + i), 0, 1);
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1, 16'(700 + i), 0, 1);
    repeat (12) applyStimulus(0, '0, 0, 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 63) == 0,
                    $urandom_range(0, 3) != 0);
    end
    repeat (40) applyStimulus(0, '0, 0, 1);

    @(negedge i_clk);
    #3;
    check("pending_xfers", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
